// File: rtl/jk_seq_pkg.sv
// Shared definitions for the JK register sequencer: opcode and FSM state
// encodings plus the opcode field width.
package jk_seq_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_NOP    = 3'd0,
      OP_CLEAR  = 3'd1,
      OP_SET    = 3'd2,
      OP_LOAD   = 3'd3,
      OP_UP     = 3'd4,
      OP_DOWN   = 3'd5,
      OP_TOGGLE = 3'd6,
      OP_RSVD   = 3'd7
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage : jk_seq_pkg

// File: rtl/jk_bank.sv
// WIDTH parallel edge-triggered JK flip-flops with asynchronous active-high
// reset to zero. J=K=0 holds, J only sets, K only clears, J=K=1 toggles.
module jk_bank #(
   parameter int WIDTH = 4
) (
   input  logic             c_i,
   input  logic             reset_i,
   input  logic [WIDTH-1:0] j_i,
   input  logic [WIDTH-1:0] k_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] q_d;

   // JK characteristic equation evaluated per bit
   always_comb begin
      q_d = (j_i & ~q_q) | (~k_i & q_q);
   end

   // Flip-flop bank state
   always_ff @(posedge c_i or posedge reset_i) begin
      if (reset_i) begin
         q_q <= {WIDTH{1'b0}};
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule : jk_bank

// File: rtl/jk_reg_sequencer.sv
// Command-driven controller for a JK flip-flop register bank. Accepts one
// command at a time (valid/ready), then drives per-bit J/K for one or more
// RUN cycles and signals completion with a one-cycle done pulse.
// Optional build macro JK_SEQ_SAT_EN: UP/DOWN counting saturates at
// all-ones / zero instead of wrapping, and sat flags the early stop.
module jk_reg_sequencer
   import jk_seq_pkg::*;
#(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             C,
   input  logic             RESET,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic [CNT_W-1:0] cmd_len,
   output logic [WIDTH-1:0] J,
   output logic [WIDTH-1:0] K,
   output logic [WIDTH-1:0] Q,
   output logic             busy,
   output logic             done,
   output logic             sat
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sat_q, sat_d;

   logic [WIDTH-1:0] q_s;
   logic [WIDTH-1:0] j_s;
   logic [WIDTH-1:0] k_s;
   logic [WIDTH-1:0] t_up_s;
   logic [WIDTH-1:0] t_dn_s;
   logic             is_count_s;
   logic             sat_stop_s;

   assign is_count_s = (op_q == OP_UP) || (op_q == OP_DOWN);

`ifdef JK_SEQ_SAT_EN
   // Stop counting before a step that would wrap past the range limits
   assign sat_stop_s = ((op_q == OP_UP)   && (&q_s)) ||
                       ((op_q == OP_DOWN) && (~|q_s));
`else
   assign sat_stop_s = 1'b0;
`endif

   // Counter toggle masks: bit i toggles when all lower bits are 1 (up) or 0 (down)
   always_comb begin : toggle_masks
      logic c_up;
      logic c_dn;
      c_up   = 1'b1;
      c_dn   = 1'b1;
      t_up_s = {WIDTH{1'b0}};
      t_dn_s = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         t_up_s[i] = c_up;
         t_dn_s[i] = c_dn;
         c_up      = c_up & q_s[i];
         c_dn      = c_dn & ~q_s[i];
      end
   end

   // FSM and command register state
   always_ff @(posedge C or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NOP;
         data_q  <= {WIDTH{1'b0}};
         cnt_q   <= {CNT_W{1'b0}};
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // Next-state: command capture, step counting and completion
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      sat_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               state_d = ST_RUN;
               op_d    = op_e'(cmd_op);
               data_d  = cmd_data;
               cnt_d   = cmd_len;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (is_count_s) begin
               if (cnt_q == {CNT_W{1'b0}}) begin
                  // Zero-length count: single idle RUN cycle
                  state_d = ST_DONE;
               end else if (sat_stop_s) begin
                  state_d = ST_DONE;
                  cnt_d   = {CNT_W{1'b0}};
                  sat_d   = 1'b1;
               end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_d = ST_DONE;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Outputs: J/K drive only in RUN, handshake/status decoded from state
   always_comb begin
      j_s       = {WIDTH{1'b0}};
      k_s       = {WIDTH{1'b0}};
      cmd_ready = (state_q == ST_IDLE);
      busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
      done      = (state_q == ST_DONE);
      if (state_q == ST_RUN) begin
         case (op_q)
            OP_CLEAR: begin
               k_s = {WIDTH{1'b1}};
            end
            OP_SET: begin
               j_s = {WIDTH{1'b1}};
            end
            OP_LOAD: begin
               j_s = data_q;
               k_s = ~data_q;
            end
            OP_UP: begin
               if ((cnt_q != {CNT_W{1'b0}}) && !sat_stop_s) begin
                  j_s = t_up_s;
                  k_s = t_up_s;
               end else begin
                  j_s = {WIDTH{1'b0}};
                  k_s = {WIDTH{1'b0}};
               end
            end
            OP_DOWN: begin
               if ((cnt_q != {CNT_W{1'b0}}) && !sat_stop_s) begin
                  j_s = t_dn_s;
                  k_s = t_dn_s;
               end else begin
                  j_s = {WIDTH{1'b0}};
                  k_s = {WIDTH{1'b0}};
               end
            end
            OP_TOGGLE: begin
               j_s = data_q;
               k_s = data_q;
            end
            default: begin
               // NOP and reserved opcode hold the bank
               j_s = {WIDTH{1'b0}};
               k_s = {WIDTH{1'b0}};
            end
         endcase
      end else begin
         j_s = {WIDTH{1'b0}};
         k_s = {WIDTH{1'b0}};
      end
   end

   jk_bank #(
      .WIDTH (WIDTH)
   ) u_bank (
      .c_i     (C),
      .reset_i (RESET),
      .j_i     (j_s),
      .k_i     (k_s),
      .q_o     (q_s)
   );

   assign J   = j_s;
   assign K   = k_s;
   assign Q   = q_s;
   assign sat = sat_q;

endmodule : jk_reg_sequencer

// File: tb/tb_jk_reg_sequencer.sv
// Directed self-checking bench for jk_reg_sequencer (WIDTH=4, CNT_W=8).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_jk_reg_sequencer;

   logic       C;
   logic       RESET;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [3:0] cmd_data;
   logic [7:0] cmd_len;
   logic [3:0] J;
   logic [3:0] K;
   logic [3:0] Q;
   logic       busy;
   logic       done;
   logic       sat;

   int checks   = 0;
   int failures = 0;

   jk_reg_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
      .C(C), .RESET(RESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_len(cmd_len),
      .J(J), .K(K), .Q(Q), .busy(busy), .done(done), .sat(sat)
   );

   initial C = 1'b0;
   always #5 C = ~C;

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Present a command for one edge (caller is in IDLE just after a falling edge)
   task automatic send(input logic [2:0] op, input logic [3:0] d, input logic [7:0] len);
      cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_len = len;
      @(negedge C);
      cmd_valid = 1'b0;
   endtask

   // LOAD a value and return once back in IDLE
   task automatic preload(input logic [3:0] v);
      send(3'd3, v, 8'd0);
      @(negedge C);
      @(negedge C);
   endtask

   task automatic test_reset();
      RESET = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; cmd_len = 8'd0;
      #1;
      checks++; if (Q !== 4'b0000) begin failures++; $display("FAIL reset_Q got=%b exp=%b", Q, 4'b0000); end
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      checks++; if ({busy, done, sat} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, sat}); end
      checks++; if ({J, K} !== 8'h00) begin failures++; $display("FAIL reset_JK got=%b exp=%b", {J, K}, 8'h00); end
      @(negedge C);
      RESET = 1'b0;
   endtask

   task automatic test_load();
      send(3'd3, 4'b1010, 8'd0);
      checks++; if ({J, K} !== 8'b1010_0101) begin failures++; $display("FAIL load_JK got=%b exp=%b", {J, K}, 8'b1010_0101); end
      checks++; if ({cmd_ready, busy, done} !== 3'b010) begin failures++; $display("FAIL load_run_flags got=%b exp=010", {cmd_ready, busy, done}); end
      @(negedge C);
      checks++; if (Q !== 4'b1010) begin failures++; $display("FAIL load_Q got=%b exp=%b", Q, 4'b1010); end
      checks++; if ({cmd_ready, busy, done} !== 3'b011) begin failures++; $display("FAIL load_done_flags got=%b exp=011", {cmd_ready, busy, done}); end
      checks++; if ({J, K} !== 8'h00) begin failures++; $display("FAIL load_done_JK got=%b exp=0", {J, K}); end
      @(negedge C);
      checks++; if ({cmd_ready, busy, done} !== 3'b100) begin failures++; $display("FAIL load_idle_flags got=%b exp=100", {cmd_ready, busy, done}); end
   endtask

   task automatic test_up_wrap();
      logic [3:0] exp_q [5];
      exp_q[0] = 4'b1111; exp_q[1] = 4'b0000; exp_q[2] = 4'b0001; exp_q[3] = 4'b0010; exp_q[4] = 4'b0011;
      preload(4'b1110);
      send(3'd4, 4'b0000, 8'd5);
      checks++; if ({J, K} !== 8'b0001_0001) begin failures++; $display("FAIL up_first_JK got=%b exp=%b", {J, K}, 8'b0001_0001); end
`ifdef JK_SEQ_SAT_EN
      @(negedge C);
      checks++; if (Q !== 4'b1111) begin failures++; $display("FAIL up_sat_step1 got=%b exp=1111", Q); end
      checks++; if ({J, K, done} !== 9'd0) begin failures++; $display("FAIL up_sat_stop_JK got=%b exp=0", {J, K, done}); end
      @(negedge C);
      checks++; if ({done, sat, Q} !== 6'b11_1111) begin failures++; $display("FAIL up_sat_done got=%b exp=111111", {done, sat, Q}); end
      @(negedge C);
      checks++; if ({cmd_ready, sat, Q} !== 6'b10_1111) begin failures++; $display("FAIL up_sat_after got=%b exp=101111", {cmd_ready, sat, Q}); end
`else
      for (int i = 0; i < 5; i++) begin
         @(negedge C);
         checks++; if (Q !== exp_q[i]) begin failures++; $display("FAIL up_wrap_step%0d got=%b exp=%b", i, Q, exp_q[i]); end
         checks++; if (done !== (i == 4)) begin failures++; $display("FAIL up_wrap_done%0d got=%b exp=%b", i, done, (i == 4)); end
      end
      checks++; if (sat !== 1'b0) begin failures++; $display("FAIL up_wrap_sat got=%b exp=0", sat); end
      @(negedge C);
      checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL up_wrap_ready got=%b exp=1", cmd_ready); end
`endif
   endtask

   task automatic test_toggle_down0();
      preload(4'b0011);
      send(3'd6, 4'b0110, 8'd0);
      checks++; if ({J, K} !== 8'b0110_0110) begin failures++; $display("FAIL toggle_JK got=%b exp=%b", {J, K}, 8'b0110_0110); end
      @(negedge C);
      checks++; if ({Q, done} !== 5'b0101_1) begin failures++; $display("FAIL toggle_Q got=%b exp=01011", {Q, done}); end
      @(negedge C);
      send(3'd5, 4'b0000, 8'd0);
      checks++; if ({J, K, busy, done} !== 10'b0000_0000_10) begin failures++; $display("FAIL down0_run got=%b exp=0000000010", {J, K, busy, done}); end
      @(negedge C);
      checks++; if ({Q, done} !== 5'b0101_1) begin failures++; $display("FAIL down0_done got=%b exp=01011", {Q, done}); end
      @(negedge C);
      checks++; if ({cmd_ready, done} !== 2'b10) begin failures++; $display("FAIL down0_idle got=%b exp=10", {cmd_ready, done}); end
   endtask

   task automatic test_down_wrap();
      preload(4'b0001);
      send(3'd5, 4'b0000, 8'd2);
      @(negedge C);
      checks++; if (Q !== 4'b0000) begin failures++; $display("FAIL down_step1 got=%b exp=0000", Q); end
`ifdef JK_SEQ_SAT_EN
      checks++; if ({J, K} !== 8'h00) begin failures++; $display("FAIL down_sat_JK got=%b exp=0", {J, K}); end
      @(negedge C);
      checks++; if ({Q, done, sat} !== 6'b0000_11) begin failures++; $display("FAIL down_sat_done got=%b exp=000011", {Q, done, sat}); end
`else
      checks++; if ({J, K} !== 8'b1111_1111) begin failures++; $display("FAIL down_wrap_JK got=%b exp=11111111", {J, K}); end
      @(negedge C);
      checks++; if ({Q, done} !== 5'b1111_1) begin failures++; $display("FAIL down_wrap_done got=%b exp=11111", {Q, done}); end
`endif
      @(negedge C);
   endtask

   task automatic test_reset_abort();
      int done_cnt;
      done_cnt = 0;
      preload(4'b0000);
      send(3'd4, 4'b0000, 8'd10);
      for (int i = 0; i < 3; i++) begin
         @(negedge C);
         if (done) done_cnt++;
      end
      checks++; if (Q !== 4'b0011) begin failures++; $display("FAIL abort_pre got=%b exp=0011", Q); end
      RESET = 1'b1;
      #1;
      checks++; if ({Q, cmd_ready, busy, done} !== 7'b0000_100) begin failures++; $display("FAIL abort_reset got=%b exp=0000100", {Q, cmd_ready, busy, done}); end
      @(negedge C);
      RESET = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge C);
         if (done) done_cnt++;
         checks++; if ({Q, cmd_ready} !== 5'b0000_1) begin failures++; $display("FAIL abort_idle%0d got=%b exp=00001", i, {Q, cmd_ready}); end
      end
      checks++; if (done_cnt !== 0) begin failures++; $display("FAIL abort_no_done got=%0d exp=0", done_cnt); end
   endtask

   task automatic test_back_to_back();
      int done_cnt;
      done_cnt = 0;
      send(3'd2, 4'b0000, 8'd0);
      cmd_valid = 1'b1; cmd_op = 3'd1;
      checks++; if ({J, K, cmd_ready} !== 9'b1111_0000_0) begin failures++; $display("FAIL b2b_set_run got=%b exp=111100000", {J, K, cmd_ready}); end
      @(negedge C);
      if (done) done_cnt++;
      checks++; if ({Q, done, cmd_ready} !== 6'b1111_10) begin failures++; $display("FAIL b2b_set_done got=%b exp=111110", {Q, done, cmd_ready}); end
      @(negedge C);
      if (done) done_cnt++;
      checks++; if ({Q, cmd_ready, busy} !== 6'b1111_10) begin failures++; $display("FAIL b2b_idle got=%b exp=111110", {Q, cmd_ready, busy}); end
      @(negedge C);
      cmd_valid = 1'b0;
      if (done) done_cnt++;
      checks++; if ({K, cmd_ready} !== 5'b1111_0) begin failures++; $display("FAIL b2b_clear_run got=%b exp=11110", {K, cmd_ready}); end
      @(negedge C);
      if (done) done_cnt++;
      checks++; if (Q !== 4'b0000) begin failures++; $display("FAIL b2b_clear_Q got=%b exp=0000", Q); end
      @(negedge C);
      if (done) done_cnt++;
      checks++; if (done_cnt !== 2) begin failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt); end
   endtask

   task automatic test_rsvd();
      int done_cnt;
      done_cnt = 0;
      preload(4'b0101);
      send(3'd7, 4'b1111, 8'd0);
      checks++; if ({J, K} !== 8'h00) begin failures++; $display("FAIL rsvd_JK got=%b exp=0", {J, K}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge C);
         if (done) done_cnt++;
         checks++; if (Q !== 4'b0101) begin failures++; $display("FAIL rsvd_Q%0d got=%b exp=0101", i, Q); end
      end
      checks++; if (done_cnt !== 1) begin failures++; $display("FAIL rsvd_done_count got=%0d exp=1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_load();
      test_up_wrap();
      test_toggle_down0();
      test_down_wrap();
      test_reset_abort();
      test_back_to_back();
      test_rsvd();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_jk_reg_sequencer

// File: doc/jk_reg_sequencer.md
Name: jk_reg_sequencer

Overview:
Command-driven controller for a WIDTH-bit register built from edge-triggered JK flip-flops. It accepts one command at a time over a valid/ready handshake and computes per-bit J/K drive each cycle. Supported operations are clear, set, parallel load, toggle-by-mask, and multi-step up/down counting. It sits between a control master and the JK register bank, and exposes the J/K drive for probing.

Parameters:
WIDTH, 4, register width in bits (>=2)
CNT_W, 8, width of step-count field for UP/DOWN

Ports:
C  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept command
cmd_op  in  3  opcode (see Behaviour)
cmd_data  in  WIDTH  load value / toggle mask
cmd_len  in  CNT_W  step count for UP/DOWN
J  out  WIDTH  J drive to register bank
K  out  WIDTH  K drive to register bank
Q  out  WIDTH  register bank state
busy  out  1  high in RUN or DONE
done  out  1  one-cycle pulse at command completion
sat  out  1  saturation flag (see Optional Feature)

Behaviour:
- Reset (async, RESET=1) values:
  - Q=0, state=IDLE, cmd_ready=1, busy=0, done=0, sat=0, J=0, K=0, step counter=0.
- Register bank, per bit, on rising C: Q <= (J & ~Q) | (~K & Q).
- Opcodes:
  - 0 NOP: J=0, K=0.
  - 1 CLEAR: J=0, K=all-ones.
  - 2 SET: J=all-ones, K=0.
  - 3 LOAD: J=data, K=~data.
  - 4 UP: J=K=t, where t[0]=1 and t[i]=&Q[i-1:0].
  - 5 DOWN: J=K=t, where t[0]=1 and t[i]=&~Q[i-1:0].
  - 6 TOGGLE: J=K=data.
  - 7: reserved, executes as NOP.
- FSM states: IDLE, RUN, DONE.
  - IDLE: cmd_ready=1, J=K=0. On an edge with cmd_valid&cmd_ready, latch op/data/len and go to RUN.
  - RUN: cmd_ready=0, busy=1. J/K are combinational from the latched op and the current Q. Each RUN cycle yields exactly one Q update at the next edge.
    - Ops 0,1,2,3,6,7: one RUN cycle, then DONE.
    - UP/DOWN with len>=1: len RUN cycles; the counter decrements each edge; go to DONE when the counter reaches 1 at an edge.
    - UP/DOWN with len=0: one RUN cycle with J=K=0 (Q unchanged), then DONE.
  - DONE: done=1, busy=1, cmd_ready=0, J=K=0. Always returns to IDLE on the next edge.
- Latency: a command accepted at edge t0 gives its first Q change at edge t0+1. done is high during the cycle after the final RUN edge. The next command can be accepted at edge t0+len+2 at the earliest (len=1 for one-shot ops).
- Wrap-around: UP from all-ones wraps to 0; DOWN from 0 wraps to all-ones.
- cmd_valid is ignored while not in IDLE. No command is queued.
- RESET asserted mid-RUN aborts the command immediately: all outputs take reset values and no done pulse is produced.
- J/K are 0 outside RUN, so the bank holds.

Optional Feature:
- Macro: JK_SEQ_SAT_EN.
- Defined:
  - UP stops before any step where Q is all-ones; DOWN stops before any step where Q is 0.
  - On stopping, the FSM goes to DONE immediately with J=K=0 in that cycle.
  - sat=1 during that DONE cycle only.
  - One-shot ops are unaffected.
- Not defined: counting wraps freely and sat is tied to 0.

Decomposition:
- Package jk_seq_pkg:
  - opcode enum (OP_NOP..OP_RSVD).
  - FSM state enum (ST_IDLE, ST_RUN, ST_DONE).
  - opcode width constant (3).
- Sub-module jk_bank:
  - WIDTH parallel JK flip-flops, rising C, async active-high RESET to 0.
  - Instantiated once; Q is taken from it.

Test Plan:
- Each scenario uses WIDTH=4.
- LOAD data=4'b1010 from Q=0 -> J=1010, K=0101 for one cycle. Q=1010 at next edge, then done=1 for one cycle, then cmd_ready=1.
- UP len=5 from Q=4'b1110:
  - Without macro -> Q sequence 1111, 0000, 0001, 0010, 0011, then done.
  - With JK_SEQ_SAT_EN -> Q=1111 after 1 step, then DONE with sat=1, and Q stays 1111.
- TOGGLE data=4'b0110 on Q=4'b0011 -> Q=0101 after one edge. DOWN len=0 -> Q unchanged, done after exactly one RUN cycle.
- UP len=10 from 0, RESET pulsed after 3 steps (Q=0011) -> Q=0, state IDLE, cmd_ready=1, no done pulse.
- cmd_valid held high with CLEAR during RUN/DONE of a SET command -> CLEAR not accepted until the first IDLE cycle. Final Q=1111 then 0000, with two done pulses.
- Opcode 7 with data=4'b1111 on Q=4'b0101 -> J=K=0, Q stays 0101, single done pulse.
